// File: rtl/carry_look_ahead_32.sv
// Registered two-level carry look-ahead adder: S = A + B + Cin, with Cout and signed overflow.
// Define CLA_INPUT_REG_EN to register A/B/Cin before the core (latency 2 instead of 1).
module carry_look_ahead_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overFlow
);

    localparam int unsigned NGRP = WIDTH / 4;
    localparam int unsigned NSEC = WIDTH / 16;

    // Carries c1..c3 of a 4-wide look-ahead block, each a flat sum of products.
    function automatic logic [2:0] lac3(input logic [2:0] g, input logic [2:0] p, input logic ci);
        lac3[0] = g[0] | (p[0] & ci);
        lac3[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        lac3[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    endfunction

    // Block generate; p[0] does not contribute, so only p[3:1] is passed.
    function automatic logic grp_gen(input logic [3:0] g, input logic [3:1] p);
        grp_gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [WIDTH-1:0] a_c, b_c;
    logic             cin_c;

`ifdef CLA_INPUT_REG_EN
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            cin_q <= Cin;
        end
    end

    assign a_c   = a_q;
    assign b_c   = b_q;
    assign cin_c = cin_q;
`else
    assign a_c   = A;
    assign b_c   = B;
    assign cin_c = Cin;
`endif

    logic [WIDTH-1:0] g, p, sum;
    logic [WIDTH:0]   c;
    logic [NGRP-1:0]  gg, gp, gc;
    logic [NSEC-1:0]  sg, sp;
    logic [NSEC:0]    sc;

    assign g = a_c & b_c;
    assign p = a_c ^ b_c;

    for (genvar k = 0; k < NGRP; k++) begin : gen_grp
        assign gg[k]            = grp_gen(g[4*k +: 4], p[4*k+1 +: 3]);
        assign gp[k]            = &p[4*k +: 4];
        assign c[4*k]           = gc[k];
        assign c[4*k+1 +: 3]    = lac3(g[4*k +: 3], p[4*k +: 3], gc[k]);
    end

    for (genvar s = 0; s < NSEC; s++) begin : gen_sec
        assign sg[s]            = grp_gen(gg[4*s +: 4], gp[4*s+1 +: 3]);
        assign sp[s]            = &gp[4*s +: 4];
        assign gc[4*s]          = sc[s];
        assign gc[4*s+1 +: 3]   = lac3(gg[4*s +: 3], gp[4*s +: 3], sc[s]);
    end

    // Section carries expanded to sum-of-products over all lower sections, so no chain forms.
    always_comb begin
        logic acc;
        logic prod;
        sc    = '0;
        acc   = 1'b0;
        prod  = 1'b0;
        sc[0] = cin_c;
        for (int j = 1; j <= int'(NSEC); j++) begin
            prod = cin_c;
            for (int k = 0; k < j; k++) prod = prod & sp[k];
            acc = prod;
            for (int k = 0; k < j; k++) begin
                prod = sg[k];
                for (int m = k + 1; m < j; m++) prod = prod & sp[m];
                acc = acc | prod;
            end
            sc[j] = acc;
        end
    end

    assign c[WIDTH] = sc[NSEC];
    assign sum      = p ^ c[WIDTH-1:0];

    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= sum;
            cout_q <= c[WIDTH];
            ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
        end
    end

    assign S        = s_q;
    assign Cout     = cout_q;
    assign overFlow = ovf_q;

endmodule

// File: tb/tb_carry_look_ahead_32.sv
// Scoreboard bench for carry_look_ahead_32: expected {S,Cout,overFlow} queued at drive time,
// popped once the pipeline latency has elapsed.
module tb_carry_look_ahead_32;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t dir_tab [14] = '{
        '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1},
        '{32'h7FFFFFFF, 32'h00000005, 1'b0, 32'h80000004, 1'b0, 1'b1},
        '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1},
        '{32'h80000000, 32'hFFFFFFFB, 1'b0, 32'h7FFFFFFB, 1'b1, 1'b1},
        '{32'h0000000A, 32'hFFFFFFFB, 1'b0, 32'h00000005, 1'b1, 1'b0},
        '{32'h00000005, 32'hFFFFFFFB, 1'b0, 32'h00000000, 1'b1, 1'b0},
        '{32'h00000005, 32'h00000005, 1'b0, 32'h0000000A, 1'b0, 1'b0},
        '{32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0, 32'hFFFFFFF6, 1'b1, 1'b0},
        '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0},
        '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0},
        '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
        '{32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1}
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] s;
    logic        cout, ovf;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    carry_look_ahead_32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .S        (s),
        .Cout     (cout),
        .overFlow (ovf)
    );

    // Reference from plain 33-bit arithmetic and sign comparison.
    function automatic logic [33:0] model(input logic [31:0] va, vb, input logic vc);
        logic [32:0] t;
        logic        o;
        t = {1'b0, va} + {1'b0, vb} + {32'b0, vc};
        o = (va[31] == vb[31]) && (t[31] != va[31]);
        return {t[31:0], t[32], o};
    endfunction

    task automatic apply(input logic [31:0] va, vb, input logic vc, input logic [33:0] e);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [33:0] e;
        rst_n = 1'b0;
        a = 32'h12345678;
        b = 32'h00000001;
        cin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tick();
            checks++;
            if ({s, cout, ovf} !== 34'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got S=%h Cout=%b overFlow=%b, expected all zero",
                         i, s, cout, ovf);
            end
        end
        exp_q.delete();
        for (int i = 1; i < LAT; i++) exp_q.push_back(34'b0);
        rst_n = 1'b1;
        apply(32'h12345678, 32'h00000001, 1'b0, {32'h12345679, 1'b0, 1'b0});
        while (exp_q.size() > 0) begin
            if (exp_q.size() < LAT) tick();
            e = exp_q.pop_front();
            checks++;
            if ({s, cout, ovf} !== e) begin
                errors++;
                $display("FAIL release: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                         s, cout, ovf, e[33:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_directed();
        logic [33:0] e;
        for (int i = 0; i < 14; i++) begin
            apply(dir_tab[i].a, dir_tab[i].b, dir_tab[i].c, {dir_tab[i].s, dir_tab[i].co, dir_tab[i].ov});
            if (exp_q.size() >= LAT) begin
                e = exp_q.pop_front();
                checks++;
                if ({s, cout, ovf} !== e) begin
                    errors++;
                    $display("FAIL directed: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                             s, cout, ovf, e[33:2], e[1], e[0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({s, cout, ovf} !== e) begin
                errors++;
                $display("FAIL directed_drain: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                         s, cout, ovf, e[33:2], e[1], e[0]);
            end
        end
    endtask

    // Carry chains of every length, new operands each cycle.
    task automatic test_back_to_back();
        logic [33:0] e;
        logic [31:0] va;
        logic        vc;
        for (int i = 0; i < 32; i++) begin
            va = 32'hFFFFFFFF >> (31 - i);
            vc = 1'($urandom_range(0, 1));
            apply(va, 32'h00000001, vc, model(va, 32'h00000001, vc));
            if (exp_q.size() >= LAT) begin
                e = exp_q.pop_front();
                checks++;
                if ({s, cout, ovf} !== e) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                             i, s, cout, ovf, e[33:2], e[1], e[0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({s, cout, ovf} !== e) begin
                errors++;
                $display("FAIL back_to_back_drain: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                         s, cout, ovf, e[33:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [33:0] e;
        apply(32'h11111111, 32'h22222222, 1'b1, model(32'h11111111, 32'h22222222, 1'b1));
        @(negedge clk);
        rst_n = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h01234567;
        tick();
        checks++;
        if ({s, cout, ovf} !== 34'b0) begin
            errors++;
            $display("FAIL mid_reset: got S=%h Cout=%b overFlow=%b, expected all zero", s, cout, ovf);
        end
        exp_q.delete();
        for (int i = 1; i < LAT; i++) exp_q.push_back(34'b0);
        rst_n = 1'b1;
        apply(32'hFFFF0000, 32'h0000FFFF, 1'b1, {32'h00000000, 1'b1, 1'b0});
        while (exp_q.size() > 0) begin
            if (exp_q.size() < LAT) tick();
            e = exp_q.pop_front();
            checks++;
            if ({s, cout, ovf} !== e) begin
                errors++;
                $display("FAIL after_mid_reset: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                         s, cout, ovf, e[33:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] e;
        logic [31:0] va, vb;
        logic        vc;
        int          nerr;
        nerr = 0;
        for (int i = 0; i < 10000; i++) begin
            va = $urandom;
            vb = $urandom;
            vc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) vb = ~va;
            apply(va, vb, vc, model(va, vb, vc));
            if (exp_q.size() >= LAT) begin
                e = exp_q.pop_front();
                checks++;
                if ({s, cout, ovf} !== e) begin
                    errors++;
                    nerr++;
                    if (nerr <= 10)
                        $display("FAIL random[%0d]: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                                 i, s, cout, ovf, e[33:2], e[1], e[0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({s, cout, ovf} !== e) begin
                errors++;
                $display("FAIL random_drain: got S=%h Cout=%b overFlow=%b, expected S=%h Cout=%b overFlow=%b",
                         s, cout, ovf, e[33:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
